// File: rtl/bet_pkg.sv
// Shared constants, FSM state encoding and bet-line payload for the bet checker.
package bet_pkg;

    localparam int unsigned NW        = 5;
    localparam int unsigned MAX_LINES = 6;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned HIT_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ARMED,
        CHECK,
        DONE
    } state_t;

    typedef struct packed {
        logic [NW-1:0] n1;
        logic [NW-1:0] n2;
        logic [NW-1:0] n3;
        logic [NW-1:0] n4;
    } line_t;

    // A draw is usable only when all four numbers are non-zero and distinct.
    function automatic logic draw_ok(input line_t w);
        return (w.n1 != '0) && (w.n2 != '0) && (w.n3 != '0) && (w.n4 != '0) &&
               (w.n1 != w.n2) && (w.n1 != w.n3) && (w.n1 != w.n4) &&
               (w.n2 != w.n3) && (w.n2 != w.n4) && (w.n3 != w.n4);
    endfunction

endpackage

// File: rtl/line_scorer.sv
// Combinational hit count of one bet line against four winning numbers.
module line_scorer
    import bet_pkg::*;
(
    input  line_t            i_line,
    input  line_t            i_win,
    output logic [HIT_W-1:0] o_hits_c
);

    function automatic logic is_hit(input logic [NW-1:0] n, input line_t w);
        return (n == w.n1) || (n == w.n2) || (n == w.n3) || (n == w.n4);
    endfunction

    assign o_hits_c = HIT_W'(is_hit(i_line.n1, i_win)) + HIT_W'(is_hit(i_line.n2, i_win)) +
                      HIT_W'(is_hit(i_line.n3, i_win)) + HIT_W'(is_hit(i_line.n4, i_win));

endmodule

// File: rtl/bet_checker.sv
// Captures bet lines, validates a draw and streams per-line hit counts plus the best line.
// Optional hit-count statistics outputs are enabled by defining BET_CHECK_STATS_EN.
module bet_checker
    import bet_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NW-1:0]    B1,
    input  logic [NW-1:0]    B2,
    input  logic [NW-1:0]    B3,
    input  logic [NW-1:0]    B4,
    input  logic [1:0]       number,
    input  logic             V,
    input  logic             finish,
    input  logic             draw_valid,
    input  logic [NW-1:0]    W1,
    input  logic [NW-1:0]    W2,
    input  logic [NW-1:0]    W3,
    input  logic [NW-1:0]    W4,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_line,
    output logic [HIT_W-1:0] res_hits,
    output logic [CNT_W-1:0] best_line,
    output logic [HIT_W-1:0] best_hits,
    output logic             done,
    output logic             draw_err,
    output logic             ovf
`ifdef BET_CHECK_STATS_EN
    ,
    output logic [HIT_W-1:0] n_hit2,
    output logic [HIT_W-1:0] n_hit3,
    output logic [HIT_W-1:0] n_hit4
`endif
);

    state_t           r_state, w_state_nxt;
    logic             r_prev_v;
    logic [1:0]       r_prev_num;
    line_t            r_buf [MAX_LINES];
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_idx, w_idx_nxt;
    line_t            r_w, w_w_nxt;
    logic             r_res_valid, w_res_valid_nxt;
    logic [HIT_W-1:0] r_res_hits, w_res_hits_nxt;
    logic [CNT_W-1:0] r_best_line, w_best_line_nxt;
    logic [HIT_W-1:0] r_best_hits, w_best_hits_nxt;
    logic             r_done, w_done_nxt;
    logic             r_draw_err, w_draw_err_nxt;
    logic             r_ovf, w_ovf_nxt;
`ifdef BET_CHECK_STATS_EN
    logic [HIT_W-1:0] r_n2, r_n3, r_n4, w_n2_nxt, w_n3_nxt, w_n4_nxt;
`endif

    logic             w_v_rise, w_event, w_clr, w_wr_en, w_hs;
    line_t            w_line_in, w_draw_in, w_sc_line, w_sc_win;
    logic [HIT_W-1:0] w_sc_hits;
    logic [CNT_W-1:0] w_nidx;

    assign w_v_rise  = V && !r_prev_v;
    assign w_event   = (r_prev_num == 2'd3) && (number == 2'd0);
    assign w_line_in = {B1, B2, B3, B4};
    assign w_draw_in = {W1, W2, W3, W4};
    assign w_hs      = r_res_valid && res_ready;
    assign w_nidx    = (r_idx == CNT_W'(MAX_LINES - 1)) ? '0 : r_idx + CNT_W'(1);

    line_scorer u_scorer (
        .i_line   (w_sc_line),
        .i_win    (w_sc_win),
        .o_hits_c (w_sc_hits)
    );

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_idx_nxt       = r_idx;
        w_w_nxt         = r_w;
        w_res_valid_nxt = r_res_valid;
        w_res_hits_nxt  = r_res_hits;
        w_best_line_nxt = r_best_line;
        w_best_hits_nxt = r_best_hits;
        w_done_nxt      = r_done;
        w_draw_err_nxt  = r_draw_err;
        w_ovf_nxt       = r_ovf;
        w_clr           = 1'b0;
        w_wr_en         = 1'b0;
        w_sc_line       = r_buf[w_nidx];
        w_sc_win        = r_w;
`ifdef BET_CHECK_STATS_EN
        w_n2_nxt        = r_n2;
        w_n3_nxt        = r_n3;
        w_n4_nxt        = r_n4;
`endif
        case (r_state)
            IDLE: begin
                if (w_v_rise) begin
                    w_clr       = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_v_rise) begin
                    w_clr = 1'b1;
                end else begin
                    if (w_event) begin
                        if (r_count == CNT_W'(MAX_LINES)) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                    if (finish && ((r_count != '0) || w_event)) begin
                        w_state_nxt = ARMED;
                    end
                end
            end
            ARMED: begin
                w_sc_line = r_buf[0];
                w_sc_win  = w_draw_in;
                if (w_v_rise) begin
                    w_clr       = 1'b1;
                    w_state_nxt = COLLECT;
                end else if (draw_valid) begin
                    if (!draw_ok(w_draw_in)) begin
                        w_draw_err_nxt = 1'b1;
                    end else begin
                        w_w_nxt         = w_draw_in;
                        w_draw_err_nxt  = 1'b0;
                        w_best_line_nxt = '0;
                        w_best_hits_nxt = '0;
                        w_idx_nxt       = '0;
                        w_res_valid_nxt = 1'b1;
                        w_res_hits_nxt  = w_sc_hits;
                        w_state_nxt     = CHECK;
`ifdef BET_CHECK_STATS_EN
                        w_n2_nxt        = '0;
                        w_n3_nxt        = '0;
                        w_n4_nxt        = '0;
`endif
                    end
                end
            end
            CHECK: begin
                if (w_hs) begin
                    // Strictly greater keeps the earliest line on ties.
                    if (r_res_hits > r_best_hits) begin
                        w_best_line_nxt = r_idx;
                        w_best_hits_nxt = r_res_hits;
                    end
`ifdef BET_CHECK_STATS_EN
                    if (r_res_hits == HIT_W'(2)) w_n2_nxt = r_n2 + HIT_W'(1);
                    if (r_res_hits == HIT_W'(3)) w_n3_nxt = r_n3 + HIT_W'(1);
                    if (r_res_hits == HIT_W'(4)) w_n4_nxt = r_n4 + HIT_W'(1);
`endif
                    if (r_idx == r_count - CNT_W'(1)) begin
                        w_res_valid_nxt = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = DONE;
                    end else begin
                        w_idx_nxt      = w_nidx;
                        w_res_hits_nxt = w_sc_hits;
                    end
                end
            end
            DONE: begin
                if (w_v_rise) begin
                    w_clr       = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_clr) begin
            w_count_nxt    = '0;
            w_draw_err_nxt = 1'b0;
            w_ovf_nxt      = 1'b0;
            w_done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_prev_v    <= 1'b0;
            r_prev_num  <= '0;
            r_buf       <= '{default: '0};
            r_count     <= '0;
            r_idx       <= '0;
            r_w         <= '0;
            r_res_valid <= 1'b0;
            r_res_hits  <= '0;
            r_best_line <= '0;
            r_best_hits <= '0;
            r_done      <= 1'b0;
            r_draw_err  <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef BET_CHECK_STATS_EN
            r_n2        <= '0;
            r_n3        <= '0;
            r_n4        <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_prev_v    <= V;
            r_prev_num  <= number;
            r_count     <= w_count_nxt;
            r_idx       <= w_idx_nxt;
            r_w         <= w_w_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_hits  <= w_res_hits_nxt;
            r_best_line <= w_best_line_nxt;
            r_best_hits <= w_best_hits_nxt;
            r_done      <= w_done_nxt;
            r_draw_err  <= w_draw_err_nxt;
            r_ovf       <= w_ovf_nxt;
`ifdef BET_CHECK_STATS_EN
            r_n2        <= w_n2_nxt;
            r_n3        <= w_n3_nxt;
            r_n4        <= w_n4_nxt;
`endif
            if (w_clr) begin
                r_buf <= '{default: '0};
            end else if (w_wr_en) begin
                r_buf[r_count] <= w_line_in;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_line  = r_idx;
    assign res_hits  = r_res_hits;
    assign best_line = r_best_line;
    assign best_hits = r_best_hits;
    assign done      = r_done;
    assign draw_err  = r_draw_err;
    assign ovf       = r_ovf;
`ifdef BET_CHECK_STATS_EN
    assign n_hit2    = r_n2;
    assign n_hit3    = r_n3;
    assign n_hit4    = r_n4;
`endif

endmodule
